// File: rtl/obj_pkg.sv
// Shared constants, FSM state type and plane-data layout for the object pattern
// fetch-and-shift stage.
package obj_pkg;

    localparam int         GFX_AW      = 12;
    localparam int         PLANES      = 3;
    localparam logic [2:0] FETCH_PHASE = 3'd3;
    localparam logic [2:0] LOAD_PHASE  = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HELD
    } obj_state_e;

    // plane[2] occupies the top byte, so the word reads {p2,p1,p0}
    typedef struct packed {
        logic [PLANES-1:0][7:0] plane;
    } gfx_word_t;

    function automatic logic [7:0] bit_rev8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
        return r;
    endfunction

endpackage

// File: rtl/obj_pattern_shifter_if.sv
// Graphics memory fetch bus between the pattern shifter (master) and the
// object graphics memory (slave).
interface obj_pattern_shifter_if;
    import obj_pkg::*;

    logic [GFX_AW-1:0] gfx_addr;
    logic              gfx_rd;
    gfx_word_t         gfx_data;
    logic              gfx_valid;

    modport master (output gfx_addr, output gfx_rd, input gfx_data, input gfx_valid);
    modport slave  (input gfx_addr, input gfx_rd, output gfx_data, output gfx_valid);

endinterface

// File: rtl/obj_plane_shift.sv
// One bitplane: 8-bit parallel-load shift register, optionally mirrored on load,
// shifting left with zero fill; the MSB is the current pixel bit.
module obj_plane_shift import obj_pkg::*; (
    input  logic       clkm_48MHZ,
    input  logic       reset,
    input  logic       load,
    input  logic       shift,
    input  logic       flip,
    input  logic [7:0] din,
    output logic       dout
);

    logic [7:0] sr;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clkm_48MHZ) begin
        if (reset)      sr <= '0;
        else if (load)  sr <= flip ? bit_rev8(din) : din;
        else if (shift) sr <= {sr[6:0], 1'b0};
    end

    assign dout = sr[7];

endmodule

// File: rtl/obj_pattern_shifter.sv
// Object pattern fetch-and-shift stage feeding QBUS of obj_bus.
// Optional build macro OBJ_LATE_CNT_EN adds the saturating late_cnt output.
module obj_pattern_shifter import obj_pkg::*; (
    input  logic                  clkm_48MHZ,
    input  logic                  reset,
    input  logic                  pix_ce,
    input  logic [2:0]            hn,
    input  logic [GFX_AW-1:0]     obj_cha,
    input  logic                  obj_cinv,
    input  logic                  inrang,
    obj_pattern_shifter_if.master gfx,
    output logic [PLANES-1:0]     qbus,
    output logic                  late_err
`ifdef OBJ_LATE_CNT_EN
    ,
    output logic [7:0]            late_cnt
`endif
);

    obj_state_e        state_q, state_d;
    logic [GFX_AW-1:0] addr_q;
    logic              cinv_q, rang_q;
    gfx_word_t         hold_q;
    logic              fetch_ev, load_ev;
    logic              capture, take, late_set;

    assign fetch_ev = pix_ce && (hn == FETCH_PHASE);
    assign load_ev  = pix_ce && (hn == LOAD_PHASE);

    // A load reaching REQ wins over a same-cycle gfx_valid: the data is too late.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        take     = 1'b0;
        late_set = 1'b0;
        case (state_q)
            IDLE: if (fetch_ev) begin
                state_d = REQ;
                capture = 1'b1;
            end
            REQ: if (load_ev) begin
                state_d  = IDLE;
                late_set = 1'b1;
            end else if (gfx.gfx_valid) begin
                state_d = HELD;
                take    = 1'b1;
            end
            HELD: if (load_ev) begin
                state_d = IDLE;
            end else if (fetch_ev) begin
                state_d  = REQ;
                capture  = 1'b1;
                late_set = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkm_48MHZ) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: the holding register is cleared on reset so a stale pattern can never reach QBUS.
    always_ff @(posedge clkm_48MHZ) begin
        if (reset) begin
            addr_q   <= '0;
            cinv_q   <= 1'b0;
            rang_q   <= 1'b0;
            hold_q   <= '0;
            late_err <= 1'b0;
        end else begin
            if (capture) begin
                addr_q <= obj_cha;
                cinv_q <= obj_cinv;
                rang_q <= inrang;
            end
            if (take)     hold_q   <= gfx.gfx_data;
            if (late_set) late_err <= 1'b1;
        end
    end

    assign gfx.gfx_addr = addr_q;
    assign gfx.gfx_rd   = (state_q == REQ);

    for (genvar gi = 0; gi < PLANES; gi++) begin : g_plane
        logic [7:0] load_data;
        assign load_data = (state_q == HELD && rang_q) ? hold_q.plane[gi] : 8'h00;

        obj_plane_shift u_shift (
            .clkm_48MHZ (clkm_48MHZ),
            .reset      (reset),
            .load       (load_ev),
            .shift      (pix_ce && !load_ev),
            .flip       (cinv_q),
            .din        (load_data),
            .dout       (qbus[gi])
        );
    end

`ifdef OBJ_LATE_CNT_EN
    always_ff @(posedge clkm_48MHZ) begin
        if (reset)                            late_cnt <= '0;
        else if (late_set && late_cnt != '1)  late_cnt <= late_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_obj_pattern_shifter.sv
// Self-checking bench for obj_pattern_shifter: directed group table, hand-built
// reset sequence and randomized groups against a pixel-level reference model.
module tb_obj_pattern_shifter;
    import obj_pkg::*;

    typedef struct {
        logic [11:0] cha;
        logic        cinv;
        logic        rang;
        logic [23:0] data;
        int          lat;      // cycles from gfx_rd to gfx_valid; >30 means never in time
        bit          skip;     // suppress this group's load phase
        logic [23:0] exp_seq;  // eight 3-bit pixels, first pixel in the top bits
    } grp_t;

    logic        clkm_48MHZ = 1'b0;
    logic        reset = 1'b1;
    logic        pix_ce = 1'b0;
    logic [2:0]  hn = 3'd0;
    logic [11:0] obj_cha = '0;
    logic        obj_cinv = 1'b0;
    logic        inrang = 1'b0;
    logic [2:0]  qbus;
    logic        late_err;
`ifdef OBJ_LATE_CNT_EN
    logic [7:0]  late_cnt;
`endif

    obj_pattern_shifter_if gfx_if ();

    obj_pattern_shifter dut (
        .clkm_48MHZ (clkm_48MHZ),
        .reset      (reset),
        .pix_ce     (pix_ce),
        .hn         (hn),
        .obj_cha    (obj_cha),
        .obj_cinv   (obj_cinv),
        .inrang     (inrang),
        .gfx        (gfx_if.master),
        .qbus       (qbus),
        .late_err   (late_err)
`ifdef OBJ_LATE_CNT_EN
        ,
        .late_cnt   (late_cnt)
`endif
    );

    initial forever #10 clkm_48MHZ = ~clkm_48MHZ;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         k = 0;
    int         c = 0;
    int         rd_age = 0;
    grp_t       cur_grp;
    grp_t       dir_tab[7];
    bit         fetched = 0;
    bit         held_pending = 0;
    bit         exp_late = 0;
    int         exp_cnt = 0;
    bit         force_valid = 0;
    logic [2:0] exp_q[$];
    logic [2:0] last_exp = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (k=%0d c=%0d)", name, act, req, k, c);
        end
    endtask

    // Pixel i shows plane bit 7-i, or bit i when the group is mirrored.
    function automatic logic [23:0] ref_seq(input logic [23:0] d, input logic cinv);
        logic [23:0] s;
        int b;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            b = cinv ? i : 7 - i;
            s[23-3*i -: 3] = {d[16+b], d[8+b], d[b]};
        end
        return s;
    endfunction

    function automatic int bump(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    // One clkm_48MHZ cycle: drive at negedge, advance the model, sample #1 after posedge.
    task automatic clk_step();
        logic [23:0] seq;
        bit          late;
        @(negedge clkm_48MHZ);
        pix_ce = (c == 0);
        hn     = (cur_grp.skip && k == 7) ? 3'd0 : 3'(k);
        if (force_valid) begin
            gfx_if.gfx_valid = 1'b1;
            gfx_if.gfx_data  = cur_grp.data;
        end else if (gfx_if.gfx_rd === 1'b1) begin
            gfx_if.gfx_valid = (rd_age == cur_grp.lat);
            gfx_if.gfx_data  = (gfx_if.gfx_addr == cur_grp.cha) ? cur_grp.data : 24'hBADBAD;
            rd_age++;
        end else begin
            gfx_if.gfx_valid = 1'b0;
            gfx_if.gfx_data  = 24'($urandom);
            rd_age = 0;
        end
        @(posedge clkm_48MHZ);
        #1;
        if (reset) begin
            exp_q.delete();
            fetched = 0; held_pending = 0; exp_late = 0; exp_cnt = 0; last_exp = '0;
        end else begin
            if (c == 0 && k == 3) begin
                fetched = 1;
                if (held_pending) begin
                    exp_late = 1;
                    exp_cnt  = bump(exp_cnt);
                end
                held_pending = 0;
                check("gfx_addr", 32'(gfx_if.gfx_addr), 32'(cur_grp.cha));
                check("gfx_rd_fetch", 32'(gfx_if.gfx_rd), 32'd1);
            end
            if (c == 0 && k == 7) begin
                if (cur_grp.skip) begin
                    held_pending = fetched && cur_grp.lat <= 30;
                end else begin
                    late = fetched && cur_grp.lat > 30;
                    if (late) begin
                        exp_late = 1;
                        exp_cnt  = bump(exp_cnt);
                    end
                    seq = (fetched && !late) ? cur_grp.exp_seq : 24'h0;
                    for (int i = 0; i < 8; i++) exp_q.push_back(seq[23-3*i -: 3]);
                    check("gfx_rd_load", 32'(gfx_if.gfx_rd), 32'd0);
                end
                fetched = 0;
            end
            if (c == 0) begin
                last_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 3'd0;
                check("qbus", 32'(qbus), 32'(last_exp));
                check("late_err", 32'(late_err), 32'(exp_late));
`ifdef OBJ_LATE_CNT_EN
                check("late_cnt", 32'(late_cnt), 32'(exp_cnt));
`endif
            end
            if (c == 4) check("qbus_between_ce", 32'(qbus), 32'(last_exp));
        end
        c = (c + 1) % 8;
        if (c == 0) k = (k + 1) % 8;
    endtask

    task automatic run_group(input grp_t g);
        cur_grp  = g;
        obj_cha  = g.cha;
        obj_cinv = g.cinv;
        inrang   = g.rang;
        do clk_step(); while (!(k == 0 && c == 0));
    endtask

    initial begin
        grp_t g;
        dir_tab[0] = '{12'h2A5, 1'b0, 1'b1, 24'hF0CCAA, 4,   1'b0, 24'hFAC688};
        dir_tab[1] = '{12'h2A5, 1'b1, 1'b1, 24'hF0CCAA, 4,   1'b0, 24'h053977};
        dir_tab[2] = '{12'h1B3, 1'b0, 1'b0, 24'hF0CCAA, 4,   1'b0, 24'h000000};
        dir_tab[3] = '{12'h0C4, 1'b0, 1'b1, 24'hF0CCAA, 6,   1'b1, 24'h000000};
        dir_tab[4] = '{12'h3D1, 1'b0, 1'b1, 24'h0F3355, 3,   1'b0, 24'h053977};
        dir_tab[5] = '{12'h3C0, 1'b0, 1'b1, 24'hF0CCAA, 255, 1'b0, 24'h000000};
        dir_tab[6] = '{12'h0FF, 1'b1, 1'b1, 24'hF0CCAA, 2,   1'b0, 24'h053977};

        cur_grp = '{12'h000, 1'b0, 1'b0, 24'h0, 255, 1'b0, 24'h0};
        gfx_if.gfx_valid = 1'b0;
        gfx_if.gfx_data  = '0;
        reset = 1'b1;
        repeat (3) clk_step();
        reset = 1'b0;
        check("rst_qbus", 32'(qbus), 32'd0);
        check("rst_gfx_rd", 32'(gfx_if.gfx_rd), 32'd0);
        check("rst_gfx_addr", 32'(gfx_if.gfx_addr), 32'd0);
        check("rst_late_err", 32'(late_err), 32'd0);

        // Order, flip, out of range, then a held group overwritten by the next fetch.
        for (int i = 0; i < 5; i++) run_group(dir_tab[i]);

        // Reset two cycles into a fetch, then a stray gfx_valid.
        cur_grp  = '{12'h155, 1'b0, 1'b1, 24'hFFFFFF, 255, 1'b0, 24'h0};
        obj_cha  = cur_grp.cha;
        obj_cinv = 1'b0;
        inrang   = 1'b1;
        while (!(k == 3 && c == 1)) clk_step();
        repeat (2) clk_step();
        reset = 1'b1;
        clk_step();
        reset = 1'b0;
        force_valid = 1'b1;
        clk_step();
        force_valid = 1'b0;
        check("abandon_gfx_rd", 32'(gfx_if.gfx_rd), 32'd0);
        check("abandon_qbus", 32'(qbus), 32'd0);
        check("abandon_late_err", 32'(late_err), 32'd0);
        do clk_step(); while (!(k == 0 && c == 0));

        // Late fetch followed by a timely one.
        for (int i = 5; i < 7; i++) run_group(dir_tab[i]);

        for (int n = 0; n < 40; n++) begin
            g.cha  = 12'($urandom);
            g.cinv = 1'($urandom);
            g.rang = ($urandom_range(0, 7) != 0);
            g.data = 24'($urandom);
            g.lat  = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 24));
            g.skip = 1'b0;
            g.exp_seq = (g.rang && g.lat <= 30) ? ref_seq(g.data, g.cinv) : 24'h0;
            run_group(g);
        end

`ifdef OBJ_LATE_CNT_EN
        reset = 1'b1;
        clk_step();
        reset = 1'b0;
        do clk_step(); while (!(k == 0 && c == 0));
        for (int n = 0; n < 300; n++) begin
            g = '{12'($urandom), 1'b0, 1'b1, 24'($urandom), 255, 1'b0, 24'h0};
            run_group(g);
        end
        check("late_cnt_saturated", 32'(late_cnt), 32'd255);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/obj_pattern_shifter.md
Name: obj_pattern_shifter

Overview:
Object pattern fetch-and-shift stage upstream of obj_bus. Once per 8-pixel group it captures the object character address obj_bus produces (OBJ_CHA, OBJ_CINV, INRANG) and fetches three bitplanes from object graphics memory. It serialises the planes into the 3-bit QBUS pixel code that obj_bus writes into its line buffers. Timebase is one 48 MHz clock; the pixel rate comes from a 6 MHz clock enable.

Parameters:
GFX_AW, 12, graphics memory address width (OBJ_CHA[11:0]).
PLANES, 3, number of bitplanes, equal to the QBUS width.
FETCH_PHASE, 3, hn[2:0] value at which the address is captured and the fetch starts.
LOAD_PHASE, 7, hn[2:0] value at which fetched data is transferred to the shifters.

Ports:
clkm_48MHZ  in  1  sole clock.
reset  in  1  synchronous, active-high.
pix_ce  in  1  one-cycle pixel enable at the 6 MHz rate.
hn  in  3  syncbus_HN[2:0] pixel phase within the group.
obj_cha  in  GFX_AW  object character address from obj_bus.
obj_cinv  in  1  horizontal pattern invert for this group.
inrang  in  1  object vertically in range; 0 forces a blank group.
gfx_addr  out  GFX_AW  graphics memory address.
gfx_rd  out  1  read request, held until gfx_valid.
gfx_data  in  8*PLANES  plane data {p2,p1,p0}; bit 7 is the leftmost pixel.
gfx_valid  in  1  one-cycle data-valid strobe.
qbus  out  PLANES  current pixel code to obj_bus (QBUS).
late_err  out  1  sticky: fetch was not complete at load time.

Behaviour:
- Reset values: qbus=0, gfx_rd=0, gfx_addr=0, late_err=0, all shifters and holding registers cleared, FSM=IDLE. Reset applied mid-fetch abandons the fetch; a gfx_valid arriving after reset is ignored.
- FSM states: IDLE, REQ, HELD.
  - IDLE -> REQ on pix_ce & hn==FETCH_PHASE. On that transition: gfx_addr<=obj_cha, capture obj_cinv and inrang into cinv_q and rang_q, assert gfx_rd.
  - REQ -> HELD on gfx_valid. On that transition: hold<=gfx_data, gfx_rd<=0.
  - HELD -> IDLE on the load event.
  - REQ at the load event: load zeros, set late_err, drop gfx_rd, go to IDLE.
  - gfx_valid outside REQ is ignored.
- Load event is pix_ce & hn==LOAD_PHASE.
  - Each plane shifter loads hold[plane], bit-reversed when cinv_q=1.
  - Loads zeros when rang_q=0 or the FSM is not in HELD.
- On every other pix_ce the shifters shift left by one with zero fill. qbus={s2[7],s1[7],s0[7]}, registered.
- qbus changes only in the cycle after pix_ce. The first pixel of a group appears one clkm_48MHZ cycle after the load pix_ce.
- A fetch capture at FETCH_PHASE while the FSM is in HELD (no load occurred): overwrite the capture, return to REQ, set late_err.
- hn wraps 7->0 with no special handling. Groups are independent.
- late_err clears only on reset.

Optional Feature:
OBJ_LATE_CNT_EN:
- Defined: adds output late_cnt [7:0]. It increments on each late_err setting event, saturates at 255, and is reset to 0.
- Undefined: no port and no counter logic. late_err behaviour is identical in both builds.

Decomposition:
- Shared package obj_pkg holds: GFX_AW, PLANES, phase constants, the FSM state enum (IDLE/REQ/HELD), and the plane-data struct type.
- One natural sub-module, obj_plane_shift: an 8-bit parallel-load, flip-capable shift register. It is instantiated PLANES times.

Test Plan:
1. Addressing and order: obj_cha=0x2A5, inrang=1, cinv=0, gfx_data={8'hF0,8'hCC,8'hAA}, valid 4 cycles after rd -> gfx_addr=0x2A5; qbus sequence 7,6,5,4,3,2,1,0 across the 8 pixels.
2. Flip: same data with cinv=1 -> qbus sequence 0,1,2,3,4,5,6,7.
3. Out of range: inrang=0 with valid data -> qbus=0 for all 8 pixels; late_err stays 0.
4. Late fetch: gfx_valid withheld past LOAD_PHASE -> group outputs 0, late_err=1, gfx_rd drops; the next group with a timely valid outputs normally.
5. Reset mid-REQ: reset asserted 2 cycles after gfx_rd, valid pulsed afterwards -> qbus=0, gfx_rd=0, FSM=IDLE, valid ignored.
6. OBJ_LATE_CNT_EN defined: 300 consecutive late groups -> late_cnt saturates at 255.
